// File: rtl/uart_led_pkg.sv
// Shared definitions for the UART LED controller.
// Contents: command byte constants, run-state enum, UART RX/TX FSM state
// enums, and helpers for bit timing and counter widths.
package uart_led_pkg;

  localparam logic [7:0] CMD_START = 8'h53;  // 'S'
  localparam logic [7:0] CMD_STOP  = 8'h50;  // 'P'
  localparam logic [7:0] CMD_CLEAR = 8'h52;  // 'R'
  localparam logic [7:0] CMD_MODE  = 8'h4D;  // 'M'

  typedef enum logic {IDLE, RUN} run_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Width able to hold 0..n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and press pulse.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   din        : raw asynchronous button level (active-high)
//   press      : one-cycle pulse on the debounced 0->1 edge
module button_debounce
  import uart_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic press
);

  localparam int            CW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2, lvl, db, db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      lvl  <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      lvl  <= s2;
      db_q <= db;
      // any change of the synchronised level restarts the stability window
      if (s2 != lvl)         cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      else                   db  <= lvl;
    end
  end

  assign press = db & ~db_q;

endmodule

// File: rtl/uart_led_ctrl.sv
// UART/button controlled LED pattern counter.
// A pattern register steps every STEP_CYCLES while running; start/stop/clear
// come from debounced buttons or single-byte UART commands ('S','P','R'),
// and every state change or clear is reported back over UART.
// Optional build macro LED_ROTATE_EN: adds a one-hot rotate mode toggled by 'M'.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   rx / tx      : UART 8N1 receive (async) / transmit (idle high)
//   button_start : start button, button_stop : stop button (async, active-high)
//   led_reset    : clear button (async, active-high)
//   led          : current pattern
//   running      : high while in RUN
module uart_led_ctrl
  import uart_led_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int BAUD            = 115200,
  parameter int NUM_LEDS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_CYCLES     = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  output logic                tx,
  input  logic                button_start,
  input  logic                button_stop,
  input  logic                led_reset,
  output logic [NUM_LEDS-1:0] led,
  output logic                running
);

  localparam int            CPB       = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int            BW        = cnt_w(CPB);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CPB - 1);
  localparam logic [BW-1:0] BIT_HALF  = BW'(CPB / 2);
  localparam int            SW        = cnt_w(STEP_CYCLES);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  // ---------------- buttons: [0]=start [1]=stop [2]=clear
  logic [2:0] btn_raw, btn_press;
  assign btn_raw = {led_reset, button_stop, button_start};

  for (genvar i = 0; i < 3; i++) begin : g_db
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .reset(reset),
      .din  (btn_raw[i]),
      .press(btn_press[i])
    );
  end

  // ---------------- UART receive
  logic          rx_s1, rx_s, rx_prev;
  rx_state_t     rx_state, rx_state_n;
  logic [BW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_valid, rx_valid_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s     <= rx_s1;
      rx_prev  <= rx_s;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_valid <= rx_valid_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_valid_n = 1'b0;
    case (rx_state)
      RX_IDLE:
        if (rx_prev && !rx_s) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      RX_START:
        if (rx_cnt == BIT_HALF) begin
          // line back high at mid start bit: glitch, drop it
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else rx_cnt_n = rx_cnt + 1'b1;
      RX_DATA:
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end else rx_cnt_n = rx_cnt + 1'b1;
      RX_STOP:
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          rx_valid_n = rx_s;  // low stop bit = framing error, byte dropped
        end else rx_cnt_n = rx_cnt + 1'b1;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- command decode (rx_shift is stable while rx_valid is high)
  logic start_ev, stop_ev, clear_ev;
  assign start_ev = btn_press[0] | (rx_valid && rx_shift == CMD_START);
  assign stop_ev  = btn_press[1] | (rx_valid && rx_shift == CMD_STOP);
  assign clear_ev = btn_press[2] | (rx_valid && rx_shift == CMD_CLEAR);
`ifdef LED_ROTATE_EN
  logic mode_ev, mode;
  assign mode_ev = rx_valid && rx_shift == CMD_MODE;
`endif

  // ---------------- run FSM
  run_state_t run_state, run_state_n;
  logic       enter_run, enter_idle;

  always_ff @(posedge clk) begin
    if (reset) run_state <= IDLE;
    else       run_state <= run_state_n;
  end

  always_comb begin
    run_state_n = run_state;
    enter_run   = 1'b0;
    enter_idle  = 1'b0;
    // stop takes precedence: a simultaneous start is discarded
    if (stop_ev) begin
      if (run_state == RUN) begin
        run_state_n = IDLE;
        enter_idle  = 1'b1;
      end
    end else if (start_ev && run_state == IDLE) begin
      run_state_n = RUN;
      enter_run   = 1'b1;
    end
  end

  assign running = (run_state == RUN);

  // ---------------- pattern stepping
  logic [SW-1:0]       step_cnt;
  logic [NUM_LEDS-1:0] pattern, next_pattern, clear_val;

`ifdef LED_ROTATE_EN
  assign next_pattern = mode ? ((pattern << 1) | (pattern >> (NUM_LEDS - 1)))
                             : pattern + 1'b1;
  assign clear_val    = mode ? NUM_LEDS'(1) : '0;
`else
  assign next_pattern = pattern + 1'b1;
  assign clear_val    = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern  <= '0;
      step_cnt <= '0;
`ifdef LED_ROTATE_EN
      mode     <= 1'b0;
`endif
    end else begin
`ifdef LED_ROTATE_EN
      if (mode_ev) begin
        mode     <= ~mode;
        pattern  <= mode ? '0 : NUM_LEDS'(1);  // seed for the new mode
        step_cnt <= '0;
      end else
`endif
      if (clear_ev) begin
        pattern  <= clear_val;
        step_cnt <= '0;
      end else if (run_state != RUN) begin
        step_cnt <= '0;
      end else if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        pattern  <= next_pattern;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  assign led = pattern;

  // ---------------- event reporting: one pending slot, newest event wins
  logic       ev_vld, pend_vld, tx_load;
  logic [7:0] ev_byte, pend_byte;

  always_comb begin
    ev_vld  = 1'b0;
    ev_byte = CMD_START;
    if (enter_run)  begin ev_vld = 1'b1; ev_byte = CMD_START; end
    if (enter_idle) begin ev_vld = 1'b1; ev_byte = CMD_STOP;  end
    if (clear_ev)   begin ev_vld = 1'b1; ev_byte = CMD_CLEAR; end
`ifdef LED_ROTATE_EN
    if (mode_ev)    begin ev_vld = 1'b1; ev_byte = CMD_MODE;  end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld  <= 1'b0;
      pend_byte <= '0;
    end else if (ev_vld) begin
      pend_vld  <= 1'b1;
      pend_byte <= ev_byte;
    end else if (tx_load) begin
      pend_vld  <= 1'b0;
    end
  end

  // ---------------- UART transmit
  tx_state_t     tx_state, tx_state_n;
  logic [BW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_n       = tx;
    tx_load    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_n = 1'b1;
        if (pend_vld) begin
          tx_load    = 1'b1;
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_shift_n = pend_byte;
          tx_n       = 1'b0;
        end
      end
      TX_START:
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
          tx_n       = tx_shift[0];
        end else tx_cnt_n = tx_cnt + 1'b1;
      TX_DATA:
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_n       = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 1'b1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_n       = tx_shift[1];
          end
        end else tx_cnt_n = tx_cnt + 1'b1;
      TX_STOP:
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
        end else tx_cnt_n = tx_cnt + 1'b1;
      default: tx_state_n = TX_IDLE;
    endcase
  end

endmodule
